// File: rtl/mips_multicycle_control.sv
// Multicycle main control FSM for the MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback from the IR opcode, drives
// all datapath enables and mux selects, and bounds memory waits with a timeout.
// Optional ADDI support is built when MIPS_CTRL_ADDI_EN is defined.
module mips_multicycle_control #(
   parameter int MAX_WAIT = 15,
   parameter int WAIT_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      R_EXEC    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
`ifdef MIPS_CTRL_ADDI_EN
      JUMP      = 4'd9,
      ADDI_EXEC = 4'd10,
      ADDI_WB   = 4'd11
`else
      JUMP      = 4'd9
`endif
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic              is_mem;
   logic              timeout;
   logic              op_lw, op_sw, op_r, op_beq, op_j, op_addi;

   // Opcode classification and memory-wait status
   always_comb begin
      op_lw   = (opcode == 6'b100011);
      op_sw   = (opcode == 6'b101011);
      op_r    = (opcode == 6'b000000);
      op_beq  = (opcode == 6'b000100);
      op_j    = (opcode == 6'b000010);
`ifdef MIPS_CTRL_ADDI_EN
      op_addi = (opcode == 6'b001000);
`else
      op_addi = 1'b0;
`endif
      is_mem  = (state_reg == FETCH) || (state_reg == MEM_READ) || (state_reg == MEM_WRITE);
      // Saturating compare: once the counter reaches the limit a not-ready cycle aborts
      timeout = is_mem && !mem_ready && (wait_cnt_reg >= WAIT_W'(MAX_WAIT));
   end

   // Next-state selection; a timeout always falls back to FETCH
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         FETCH:     if (mem_ready) state_next = DECODE;
         DECODE: begin
            if (op_lw || op_sw)  state_next = MEM_ADDR;
            else if (op_r)       state_next = R_EXEC;
            else if (op_beq)     state_next = BRANCH;
            else if (op_j)       state_next = JUMP;
`ifdef MIPS_CTRL_ADDI_EN
            else if (op_addi)    state_next = ADDI_EXEC;
`endif
            else                 state_next = FETCH;
         end
         MEM_ADDR:  state_next = op_lw ? MEM_READ : MEM_WRITE;
         MEM_READ: begin
            if (mem_ready)       state_next = MEM_WB;
            else if (timeout)    state_next = FETCH;
         end
         MEM_WB:    state_next = FETCH;
         MEM_WRITE: if (mem_ready || timeout) state_next = FETCH;
         R_EXEC:    state_next = R_WB;
         R_WB:      state_next = FETCH;
         BRANCH:    state_next = FETCH;
         JUMP:      state_next = FETCH;
`ifdef MIPS_CTRL_ADDI_EN
         ADDI_EXEC: state_next = ADDI_WB;
         ADDI_WB:   state_next = FETCH;
`endif
         default:   state_next = FETCH;
      endcase
   end

   // State and wait-counter registers; counter runs only while stalled in a memory state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= FETCH;
         wait_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (is_mem && !mem_ready && !timeout && (state_next == state_reg))
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
         else
            wait_cnt_reg <= '0;
      end
   end

   // Moore output decode, forced to zero while reset is held
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      mem_timeout   = 1'b0;
      if (rst_n) begin
         mem_timeout = timeout;
         case (state_reg)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            DECODE: begin
               alu_src_b  = 2'b11;
               illegal_op = !(op_lw || op_sw || op_r || op_beq || op_j || op_addi);
            end
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            R_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
            end
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
`ifdef MIPS_CTRL_ADDI_EN
            ADDI_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            ADDI_WB: begin
               reg_write = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign state = state_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: an instruction-level model
// expands each instruction into its expected per-cycle state/output trace.
module tb_mips_multicycle_control;

   localparam int MAXW = 15;
   localparam int S_FETCH = 0, S_DECODE = 1, S_MADDR = 2, S_MREAD = 3, S_MWB = 4,
                  S_MWRITE = 5, S_REXEC = 6, S_RWB = 7, S_BR = 8, S_J = 9,
                  S_AEXEC = 10, S_AWB = 11;

   logic clk = 1'b0;
   logic rst_n;
   logic [5:0] opcode;
   logic mem_ready;
   logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic illegal_op, mem_timeout;
   logic [3:0] state;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      int         st;
      logic       mr;
      logic [5:0] op;
      logic       ill;
      logic       to;
   } cyc_t;

   cyc_t       plan[$];
   logic [3:0] obs_st[$];
   logic [17:0] obs_v[$];

   always #5 clk = ~clk;

   mips_multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
      .state(state)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [17:0] observed();
      return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
              mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
              pc_source, illegal_op, mem_timeout};
   endfunction

   // Control word the datasheet table demands for a state (same field order as observed())
   function automatic logic [17:0] exp_vec(int st, logic mr, logic ill, logic to);
      logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa;
      logic [1:0] asb, aop, psrc;
      {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa} = '0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         S_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
         S_DECODE: asb = 2'b11;
         S_MADDR:  begin asa = 1; asb = 2'b10; end
         S_MREAD:  begin mrd = 1; iod = 1; end
         S_MWB:    begin rw = 1; m2r = 1; end
         S_MWRITE: begin mwr = 1; iod = 1; end
         S_REXEC:  begin asa = 1; aop = 2'b10; end
         S_RWB:    begin rw = 1; rd = 1; end
         S_BR:     begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
         S_J:      begin pw = 1; psrc = 2'b10; end
         S_AEXEC:  begin asa = 1; asb = 2'b10; end
         S_AWB:    rw = 1;
         default:  ;
      endcase
      return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, ill, to};
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input int st, input logic mr, input logic [5:0] op,
                       input logic ill, input logic to);
      cyc_t c;
      c.st = st; c.mr = mr; c.op = op; c.ill = ill; c.to = to;
      plan.push_back(c);
   endtask

   // A memory state waits 'waits' not-ready cycles; more than MAXW aborts on cycle MAXW+1
   task automatic plan_mem(input int st, input int waits, input logic [5:0] op,
                           input logic scramble, output logic aborted);
      aborted = 1'b0;
      if (waits > MAXW) begin
         for (int i = 0; i < MAXW; i++) push(st, 1'b0, scramble ? 6'($urandom) : op, 0, 0);
         push(st, 1'b0, scramble ? 6'($urandom) : op, 0, 1);
         aborted = 1'b1;
      end else begin
         for (int i = 0; i < waits; i++) push(st, 1'b0, scramble ? 6'($urandom) : op, 0, 0);
         push(st, 1'b1, scramble ? 6'($urandom) : op, 0, 0);
      end
   endtask

   task automatic plan_instr(input logic [5:0] op, input int fw, input int mw);
      logic ab;
      logic addi_en;
`ifdef MIPS_CTRL_ADDI_EN
      addi_en = 1'b1;
`else
      addi_en = 1'b0;
`endif
      $display("instr opcode=%06b fetch_waits=%0d mem_waits=%0d", op, fw, mw);
      plan_mem(S_FETCH, fw, op, 1'b1, ab);
      if (ab) return;
      if (op == 6'b100011) begin
         push(S_DECODE, rnd_bit(), op, 0, 0);
         push(S_MADDR, rnd_bit(), op, 0, 0);
         plan_mem(S_MREAD, mw, op, 1'b0, ab);
         if (!ab) push(S_MWB, rnd_bit(), op, 0, 0);
      end else if (op == 6'b101011) begin
         push(S_DECODE, rnd_bit(), op, 0, 0);
         push(S_MADDR, rnd_bit(), op, 0, 0);
         plan_mem(S_MWRITE, mw, op, 1'b0, ab);
      end else if (op == 6'b000000) begin
         push(S_DECODE, rnd_bit(), op, 0, 0);
         push(S_REXEC, rnd_bit(), op, 0, 0);
         push(S_RWB, rnd_bit(), op, 0, 0);
      end else if (op == 6'b000100) begin
         push(S_DECODE, rnd_bit(), op, 0, 0);
         push(S_BR, rnd_bit(), op, 0, 0);
      end else if (op == 6'b000010) begin
         push(S_DECODE, rnd_bit(), op, 0, 0);
         push(S_J, rnd_bit(), op, 0, 0);
      end else if (op == 6'b001000 && addi_en) begin
         push(S_DECODE, rnd_bit(), op, 0, 0);
         push(S_AEXEC, rnd_bit(), op, 0, 0);
         push(S_AWB, rnd_bit(), op, 0, 0);
      end else begin
         push(S_DECODE, rnd_bit(), op, 1, 0);
      end
   endtask

   // Drive the planned cycles and capture what the DUT shows mid-cycle (no checking here)
   task automatic play();
      obs_st.delete();
      obs_v.delete();
      foreach (plan[i]) begin
         mem_ready = plan[i].mr;
         opcode    = plan[i].op;
         #3;
         obs_st.push_back(state);
         obs_v.push_back(observed());
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
      repeat (3) @(posedge clk);
      #3;
      n_total++;
      if (state !== 4'd0) $display("FAIL reset_state got %0d want 0", state);
      else n_pass++;
      n_total++;
      if (observed() !== 18'd0) $display("FAIL reset_outputs got %b want %b", observed(), 18'd0);
      else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      $display("reset released");
   endtask

   task automatic test_directed();
      plan.delete();
      plan_instr(6'b000000, 0, 0);
      plan_instr(6'b100011, 0, 0);
      plan_instr(6'b101011, 0, 0);
      plan_instr(6'b000100, 0, 0);
      plan_instr(6'b000010, 0, 0);
      plan_instr(6'b000000, 3, 0);
      plan_instr(6'b000000, 16, 0);
      plan_instr(6'b111111, 0, 0);
      plan_instr(6'b001000, 0, 0);
      play();
      foreach (plan[i]) begin
         n_total++;
         if (obs_st[i] !== 4'(plan[i].st))
            $display("FAIL directed_state cyc=%0d got %0d want %0d", i, obs_st[i], plan[i].st);
         else n_pass++;
         n_total++;
         if (obs_v[i] !== exp_vec(plan[i].st, plan[i].mr, plan[i].ill, plan[i].to))
            $display("FAIL directed_outputs cyc=%0d state=%0d got %b want %b", i, plan[i].st,
                     obs_v[i], exp_vec(plan[i].st, plan[i].mr, plan[i].ill, plan[i].to));
         else n_pass++;
      end
   endtask

   task automatic test_wait_bounds();
      plan.delete();
      plan_instr(6'b100011, 15, 15);   // ready arrives exactly at the limit: completes
      plan_instr(6'b101011, 2, 16);    // store aborts in MEM_WRITE
      plan_instr(6'b100011, 0, 16);    // load aborts in MEM_READ
      plan_instr(6'b101011, 0, 15);
      plan_instr(6'b000100, 1, 0);
      play();
      foreach (plan[i]) begin
         n_total++;
         if (obs_st[i] !== 4'(plan[i].st))
            $display("FAIL waits_state cyc=%0d got %0d want %0d", i, obs_st[i], plan[i].st);
         else n_pass++;
         n_total++;
         if (obs_v[i] !== exp_vec(plan[i].st, plan[i].mr, plan[i].ill, plan[i].to))
            $display("FAIL waits_outputs cyc=%0d state=%0d got %b want %b", i, plan[i].st,
                     obs_v[i], exp_vec(plan[i].st, plan[i].mr, plan[i].ill, plan[i].to));
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [5:0] ops[7];
      ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
      ops[4] = 6'b000010; ops[5] = 6'b001000; ops[6] = 6'b000000;
      plan.delete();
      for (int n = 0; n < 40; n++) begin
         logic [5:0] op;
         int fw, mw;
         op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
         fw = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(0, 17);
         mw = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(0, 17);
         plan_instr(op, fw, mw);
      end
      play();
      foreach (plan[i]) begin
         n_total++;
         if (obs_st[i] !== 4'(plan[i].st))
            $display("FAIL random_state cyc=%0d got %0d want %0d", i, obs_st[i], plan[i].st);
         else n_pass++;
         n_total++;
         if (obs_v[i] !== exp_vec(plan[i].st, plan[i].mr, plan[i].ill, plan[i].to))
            $display("FAIL random_outputs cyc=%0d state=%0d got %b want %b", i, plan[i].st,
                     obs_v[i], exp_vec(plan[i].st, plan[i].mr, plan[i].ill, plan[i].to));
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      logic ab;
      plan.delete();
      $display("instr opcode=101011 interrupted by reset in MEM_WRITE");
      push(S_FETCH, 1'b1, 6'b101011, 0, 0);
      push(S_DECODE, 1'b0, 6'b101011, 0, 0);
      push(S_MADDR, 1'b0, 6'b101011, 0, 0);
      push(S_MWRITE, 1'b0, 6'b101011, 0, 0);
      push(S_MWRITE, 1'b0, 6'b101011, 0, 0);
      play();
      foreach (plan[i]) begin
         n_total++;
         if (obs_st[i] !== 4'(plan[i].st) ||
             obs_v[i] !== exp_vec(plan[i].st, plan[i].mr, plan[i].ill, plan[i].to))
            $display("FAIL pre_reset cyc=%0d got st=%0d %b want st=%0d %b", i, obs_st[i], obs_v[i],
                     plan[i].st, exp_vec(plan[i].st, plan[i].mr, plan[i].ill, plan[i].to));
         else n_pass++;
      end
      // Still in MEM_WRITE with memory stalled: pull reset between clock edges
      mem_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (mem_write !== 1'b0) $display("FAIL async_mem_write got %b want 0", mem_write);
      else n_pass++;
      n_total++;
      if (state !== 4'd0) $display("FAIL async_state got %0d want 0", state);
      else n_pass++;
      n_total++;
      if (observed() !== 18'd0) $display("FAIL async_outputs got %b want %b", observed(), 18'd0);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      plan.delete();
      plan_instr(6'b000000, 0, 0);
      plan_instr(6'b100011, 1, 2);
      play();
      foreach (plan[i]) begin
         n_total++;
         if (obs_st[i] !== 4'(plan[i].st))
            $display("FAIL restart_state cyc=%0d got %0d want %0d", i, obs_st[i], plan[i].st);
         else n_pass++;
         n_total++;
         if (obs_v[i] !== exp_vec(plan[i].st, plan[i].mr, plan[i].ill, plan[i].to))
            $display("FAIL restart_outputs cyc=%0d state=%0d got %b want %b", i, plan[i].st,
                     obs_v[i], exp_vec(plan[i].st, plan[i].mr, plan[i].ill, plan[i].to));
         else n_pass++;
      end
      ab = 1'b0;
      if (ab) $display("unreachable");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_wait_bounds();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle main control FSM for the MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback from the IR opcode.
- Produces the 2-bit alu_op consumed by alu_control, plus all datapath enables and mux selects.
- Adds a memory ready handshake with a bounded wait timeout.

Parameters:
MAX_WAIT, 15, max consecutive not-ready cycles tolerated in a memory state before abort
WAIT_W, 4, width of wait counter; must hold MAX_WAIT

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], stable from DECODE onward
mem_ready  input  1  memory completes access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
i_or_d  output  1  0=PC address, 1=ALUOut address
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
mem_to_reg  output  1  1=MDR to register file
reg_dst  output  1  1=rd, 0=rt
reg_write  output  1  register file write
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=4, 10=sign-ext imm, 11=imm<<2
alu_op  output  2  00=add, 01=sub, 10=use funct
pc_source  output  2  00=ALU, 01=ALUOut, 10=jump target
illegal_op  output  1  one-cycle pulse on unsupported opcode
mem_timeout  output  1  one-cycle pulse on memory wait abort
state  output  4  current state, debug

Behaviour:
- Reset is asynchronous and active-low on rst_n. Clock is clk.
- While rst_n=0: state=FETCH(0), wait counter=0, every output 0 (gated).
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
- Outputs are Moore decodes of state, except ir_write/pc_write in FETCH, illegal_op and mem_timeout. Unlisted outputs are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write assert only in the cycle mem_ready=1; next state DECODE.
  - Otherwise hold in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011/101011 -> MEM_ADDR
  - 000000 -> R_EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC (only with feature)
  - anything else -> illegal_op=1 this cycle, next FETCH
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, i_or_d=1; advance to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; advance to FETCH on mem_ready.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- Memory states are FETCH, MEM_READ and MEM_WRITE.
- Wait counter behaviour:
  - Clears on entry to any memory state.
  - Increments each cycle with mem_ready=0.
  - Saturating compare against MAX_WAIT.
- Timeout: counter==MAX_WAIT and mem_ready=0 -> mem_timeout=1 for that cycle, no writes, next FETCH with counter cleared.
- Simultaneous: mem_ready=1 on the cycle counter==MAX_WAIT -> access completes normally, no timeout.
- Zero-wait cycle counts: lw 5, sw 4, R-type 4, beq 3, j 3, addi 4.
- Async reset mid-instruction aborts immediately; no partial write asserted after reset edge.

Optional Feature:
- Macro: MIPS_CTRL_ADDI_EN
- Defined: opcode 001000 -> ADDI_EXEC (alu_src_a=1, alu_src_b=10, alu_op=00) -> ADDI_WB (reg_write=1, reg_dst=0, mem_to_reg=0) -> FETCH.
- Undefined: states 10/11 not built; 001000 is illegal (illegal_op pulse in DECODE, return to FETCH).

Test Plan:
- Reset then release with mem_ready=1, opcode=000000 -> states 0,1,6,7,0. In state 6 alu_op=10; in state 7 reg_write=1, reg_dst=1.
- opcode=100011, mem_ready=1 -> states 0,1,2,3,4,0. MEM_WB has reg_write=1, mem_to_reg=1. opcode=101011 -> 0,1,2,5,0 with mem_write=1 only in state 5.
- opcode=000100 -> BRANCH shows alu_op=01, pc_write_cond=1, pc_source=01. opcode=000010 -> JUMP shows pc_write=1, pc_source=10.
- FETCH with mem_ready=0 for 3 cycles then 1 -> FETCH held 4 cycles; ir_write/pc_write high only on 4th. mem_ready=0 for 16 cycles -> mem_timeout pulse on 16th cycle, back to FETCH, no ir_write.
- opcode=111111 -> illegal_op=1 in DECODE, next FETCH. opcode=001000 -> ADDI path with MIPS_CTRL_ADDI_EN, illegal_op without.
- Drop rst_n in MEM_WRITE with mem_ready=0 -> mem_write=0 immediately, state=0; after release fetch restarts.
